retire_commit: RTL and testbench

RETIRE_COMMIT -- requirements
Module: retire_commit

---
 rtl/retire_commit.sv | 141 ++++++++++++++
 tb/tb_retire_commit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_commit.sv
// In-order retire stage: circular reorder buffer that commits completed head entries to the ARF.
// Define RETIRE_DUAL_EN to retire up to two entries per cycle; otherwise at most one.
module retire_commit #(
  parameter int AR_SIZE   = 6,
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  input  logic [AR_SIZE-1:0] alloc_dest,
  output logic               alloc_ready,
  output logic [TAG_W-1:0]   alloc_tag,
  input  logic               cmpl_valid,
  input  logic [TAG_W-1:0]   cmpl_tag,
  input  logic [31:0]        cmpl_data,
  input  logic               flush,
  output logic               write_en,
  output logic [AR_SIZE-1:0] write_addr1,
  output logic [31:0]        write_data1,
  output logic [AR_SIZE-1:0] write_addr2,
  output logic [31:0]        write_data2,
  output logic [1:0]         retire_count,
  output logic               empty
);

  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [AR_SIZE-1:0]   r_dest [ROB_DEPTH];
  logic [31:0]          r_data [ROB_DEPTH];
  logic [TAG_W-1:0]     r_head;
  logic [TAG_W-1:0]     r_tail;
  logic [TAG_W:0]       r_count;

  logic                 r_write_en;
  logic [AR_SIZE-1:0]   r_waddr1;
  logic [31:0]          r_wdata1;
  logic [AR_SIZE-1:0]   r_waddr2;
  logic [31:0]          r_wdata2;
  logic [1:0]           r_ret_cnt;

  logic                 w_alloc;
  logic                 w_ret1;
  logic                 w_ret2;
  logic [1:0]           w_ret_n;
  logic                 w_cmpl_hit;

`ifdef RETIRE_DUAL_EN
  logic [TAG_W-1:0]     w_head1;
  assign w_head1 = r_head + 1'b1;
  // Second slot only ever retires behind the head, preserving program order.
  assign w_ret2  = w_ret1 && r_valid[w_head1] && r_done[w_head1];
`else
  assign w_ret2  = 1'b0;
`endif

  assign alloc_ready = (r_count < (TAG_W+1)'(ROB_DEPTH));
  assign alloc_tag   = r_tail;
  assign empty       = (r_count == '0);
  assign w_alloc     = alloc_valid && alloc_ready;
  assign w_ret1      = r_valid[r_head] && r_done[r_head];
  assign w_ret_n     = {w_ret2, w_ret1 && !w_ret2};
  assign w_cmpl_hit  = cmpl_valid && r_valid[cmpl_tag];

  assign write_en     = r_write_en;
  assign write_addr1  = r_waddr1;
  assign write_data1  = r_wdata1;
  assign write_addr2  = r_waddr2;
  assign write_data2  = r_wdata2;
  assign retire_count = r_ret_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_done     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_write_en <= 1'b0;
      r_waddr1   <= '0;
      r_wdata1   <= '0;
      r_waddr2   <= '0;
      r_wdata2   <= '0;
      r_ret_cnt  <= '0;
    end else if (flush) begin
      r_valid    <= '0;
      r_done     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_write_en <= 1'b0;
      r_waddr1   <= '0;
      r_wdata1   <= '0;
      r_waddr2   <= '0;
      r_wdata2   <= '0;
      r_ret_cnt  <= '0;
    end else begin
      // Later assignments win: retire clears an entry completed in the same cycle,
      // and allocation targets the tail slot, which is never valid when allocating.
      if (w_cmpl_hit) r_done[cmpl_tag] <= 1'b1;
      if (w_ret1) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
      end
`ifdef RETIRE_DUAL_EN
      if (w_ret2) begin
        r_valid[w_head1] <= 1'b0;
        r_done[w_head1]  <= 1'b0;
      end
`endif
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      r_head  <= r_head + TAG_W'(w_ret_n);
      r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_ret_n);

      r_write_en <= w_ret1;
      r_waddr1   <= w_ret1 ? r_dest[r_head] : '0;
      r_wdata1   <= w_ret1 ? r_data[r_head] : '0;
`ifdef RETIRE_DUAL_EN
      r_waddr2   <= w_ret2 ? r_dest[w_head1] : '0;
      r_wdata2   <= w_ret2 ? r_data[w_head1] : '0;
`else
      r_waddr2   <= '0;
      r_wdata2   <= '0;
`endif
      r_ret_cnt  <= w_ret_n;
    end
  end

  // Payload storage carries no reset; the valid/done bits qualify it.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (w_cmpl_hit) r_data[cmpl_tag] <= cmpl_data;
      if (w_alloc)    r_dest[r_tail]   <= alloc_dest;
    end
  end

endmodule

// File: tb/tb_retire_commit.sv
// Bench for retire_commit: directed scenarios plus random traffic against a queue-based model.
module tb_retire_commit;
  localparam int AR = 6;
  localparam int D  = 16;
  localparam int TW = 4;
`ifdef RETIRE_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [AR-1:0] alloc_dest;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          cmpl_valid;
  logic [TW-1:0] cmpl_tag;
  logic [31:0]   cmpl_data;
  logic          flush;
  logic          write_en;
  logic [AR-1:0] write_addr1;
  logic [31:0]   write_data1;
  logic [AR-1:0] write_addr2;
  logic [31:0]   write_data2;
  logic [1:0]    retire_count;
  logic          empty;

  retire_commit #(.AR_SIZE(AR), .ROB_DEPTH(D), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .flush(flush),
    .write_en(write_en), .write_addr1(write_addr1), .write_data1(write_data1),
    .write_addr2(write_addr2), .write_data2(write_data2),
    .retire_count(retire_count), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: program-ordered queue of in-flight tags plus per-tag payload.
  int          q[$];
  int          mdest[D];
  logic [31:0] mdata[D];
  bit          mdone[D];
  int          mtail;
  logic [31:0] e_we, e_a1, e_d1, e_a2, e_d2, e_rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mtail = 0;
    for (int i = 0; i < D; i++) mdone[i] = 1'b0;
    e_we = 0; e_a1 = 0; e_d1 = 0; e_a2 = 0; e_d2 = 0; e_rc = 0;
  endtask

  task automatic model_step(input bit a, input int dst, input bit cv, input int ct,
                            input logic [31:0] cd, input bit fl);
    int n;
    int sz0;
    sz0 = q.size();
    if (fl) begin
      model_reset();
      return;
    end
    n = 0;
    if (sz0 > 0 && mdone[q[0]]) n = 1;
    if (DUAL && n == 1 && sz0 > 1 && mdone[q[1]]) n = 2;
    e_we = (n > 0) ? 1 : 0;
    e_a1 = (n > 0) ? mdest[q[0]] : 0;
    e_d1 = (n > 0) ? mdata[q[0]] : 0;
    e_a2 = (n == 2) ? mdest[q[1]] : 0;
    e_d2 = (n == 2) ? mdata[q[1]] : 0;
    e_rc = n;
    for (int i = 0; i < n; i++) begin
      mdone[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (cv) begin
      foreach (q[i]) begin
        if (q[i] == ct) begin
          mdone[ct] = 1'b1;
          mdata[ct] = cd;
        end
      end
    end
    if (a && sz0 < D) begin
      mdest[mtail] = dst;
      mdone[mtail] = 1'b0;
      q.push_back(mtail);
      mtail = (mtail + 1) % D;
    end
  endtask

  task automatic check_all();
    chk("alloc_ready", alloc_ready, (q.size() < D) ? 1 : 0);
    chk("alloc_tag", alloc_tag, mtail);
    chk("empty", empty, (q.size() == 0) ? 1 : 0);
    chk("write_en", write_en, e_we);
    chk("write_addr1", write_addr1, e_a1);
    chk("write_data1", write_data1, e_d1);
    chk("write_addr2", write_addr2, e_a2);
    chk("write_data2", write_data2, e_d2);
    chk("retire_count", retire_count, e_rc);
  endtask

  // Check current outputs, drive one cycle of inputs, advance to the next falling edge.
  task automatic step(input bit a, input int dst, input bit cv, input int ct,
                      input logic [31:0] cd, input bit fl);
    check_all();
    alloc_valid = a;
    alloc_dest  = AR'(dst);
    cmpl_valid  = cv;
    cmpl_tag    = TW'(ct);
    cmpl_data   = cd;
    flush       = fl;
    model_step(a, dst, cv, ct, cd, fl);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_dest = '0; cmpl_valid = 1'b0;
    cmpl_tag = '0; cmpl_data = '0; flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_write_en", write_en, 0);
    chk("rst_retire_count", retire_count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    rst = 1'b0;

    // Single entry: alloc, complete, retire two edges after the completion is issued.
    step(1, 5, 0, 0, 32'h0, 0);
    step(0, 0, 1, 0, 32'hDEADBEEF, 0);
    idle(1);
    chk("r037_we", write_en, 1);
    chk("r037_addr1", write_addr1, 5);
    chk("r037_data1", write_data1, 32'hDEADBEEF);
    chk("r037_addr2", write_addr2, 0);
    chk("r037_rc", retire_count, 1);
    idle(1);

    // Out-of-order completion must wait for the older entry.
    step(0, 0, 0, 0, 32'h0, 1);
    step(1, 3, 0, 0, 32'h0, 0);
    step(1, 4, 0, 0, 32'h0, 0);
    step(0, 0, 1, 1, 32'h11111111, 0);
    idle(1);
    chk("r038_no_retire", write_en, 0);
    step(0, 0, 1, 0, 32'h22222222, 0);
    idle(1);
    chk("r038_addr1", write_addr1, 3);
    chk("r038_rc", retire_count, DUAL ? 2 : 1);
    chk("r038_addr2", write_addr2, DUAL ? 4 : 0);
    idle(1);
    if (!DUAL) chk("r038_second_addr1", write_addr1, 4);
    idle(1);

    // Fill to capacity; extra alloc is dropped; one retire re-opens allocation.
    step(0, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < D; i++) step(1, i + 10, 0, 0, 32'h0, 0);
    chk("r039_full_ready", alloc_ready, 0);
    chk("r039_full_tag", alloc_tag, 0);
    step(1, 63, 0, 0, 32'h0, 0);
    chk("r039_tag_unchanged", alloc_tag, 0);
    step(0, 0, 1, 0, 32'hA5A5A5A5, 0);
    idle(1);
    chk("r039_retire", write_en, 1);
    chk("r039_ready_again", alloc_ready, 1);

    // Flush cancels a retire that would otherwise happen this cycle.
    step(0, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 6; i++) step(1, i + 1, 0, 0, 32'h0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 1, i, 32'h1000 + i, 0);
    step(0, 0, 1, 0, 32'h1000, 0);
    step(0, 0, 0, 0, 32'h0, 1);
    chk("r041_we", write_en, 0);
    chk("r041_empty", empty, 1);
    chk("r041_tag", alloc_tag, 0);
    idle(1);

    // Move head to 15, then retire entries 15 and 0 together across the wrap.
    for (int i = 0; i < 15; i++) step(1, i + 1, (i > 0), i - 1, 32'h2000 + i, 0);
    step(0, 0, 1, 14, 32'h2000 + 14, 0);
    idle(20);
    step(1, 7, 0, 0, 32'h0, 0);
    step(1, 9, 0, 0, 32'h0, 0);
    step(0, 0, 1, 0, 32'hB0B0B0B0, 0);
    step(0, 0, 1, 15, 32'hF0F0F0F0, 0);
    idle(1);
    chk("r040_rc", retire_count, DUAL ? 2 : 1);
    chk("r040_addr1", write_addr1, 7);
    chk("r040_data1", write_data1, 32'hF0F0F0F0);
    chk("r040_addr2", write_addr2, DUAL ? 9 : 0);
    idle(2);

    // Asynchronous reset with three completed entries pending retire.
    step(0, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(1, 20 + i, 0, 0, 32'h0, 0);
    step(0, 0, 1, 2, 32'h3002, 0);
    step(0, 0, 1, 1, 32'h3001, 0);
    step(0, 0, 1, 0, 32'h3000, 0);
    alloc_valid = 1'b0; cmpl_valid = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    chk("r042_we", write_en, 0);
    chk("r042_rc", retire_count, 0);
    chk("r042_addr1", write_addr1, 0);
    chk("r042_empty", empty, 1);
    chk("r042_ready", alloc_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(4);

    // Random traffic with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      bit a, cv, fl;
      int ct;
      a  = ($urandom_range(0, 99) < 60);
      cv = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 3);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        ct = q[$urandom_range(0, q.size() - 1)];
      else
        ct = $urandom_range(0, D - 1);
      step(a, $urandom_range(0, 63), cv, ct, $urandom, fl);
    end
    idle(20);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
